// File: rtl/mm_pkg.sv
// Shared types and defaults for the main-memory responder.
package mm_pkg;

    localparam int MM_DATA_W = 8;
    localparam int MM_ADDR_W = 8;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } mm_state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } mm_op_t;

endpackage

// File: rtl/mm_delay_counter.sv
// Loadable down-counter; zero_next flags that the count after this edge is zero.
module mm_delay_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_next
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    // Saturates at zero so a stray decrement never wraps.
    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_val;
        end else if (dec && (count_reg != '0)) begin
            count_next = count_reg - 1'b1;
        end
    end

    assign zero_next = (count_next == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/main_mem_responder.sv
// Fixed-latency main-memory responder for the data cache miss/write-back port.
module main_mem_responder
    import mm_pkg::*;
#(
    parameter int DATA_W  = MM_DATA_W,
    parameter int ADDR_W  = MM_ADDR_W,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mm_read,
    input  logic              mm_write,
    input  logic [ADDR_W-1:0] mm_addr,
    input  logic [DATA_W-1:0] cache_to_mem,
    output logic [DATA_W-1:0] mem_to_cache,
    output logic              mm_ack,
    output logic              mm_busy
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > (1 << CNT_W) - 1) begin : g_latency_check
        $error("main_mem_responder: LATENCY must be within 1..15");
    end

    mm_state_t         state_reg;
    mm_op_t            op_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              ack_reg;
    logic              busy_reg;

    logic [DATA_W-1:0] mem_array [DEPTH];

    mm_op_t            acc_op;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic              accept;
    logic              enter_ack;
    logic              cnt_zero_next;

    // In IDLE the live request is used so LATENCY=1 can complete without a latch stage.
    always_comb begin
        acc_op   = op_reg;
        acc_addr = addr_reg;
        acc_data = wdata_reg;
        if (state_reg == IDLE) begin
            acc_op   = mm_write ? OP_WR : OP_RD;
            acc_addr = mm_addr;
            acc_data = cache_to_mem;
        end
    end

    assign accept    = (state_reg == IDLE) && (mm_read || mm_write);
    assign enter_ack = (accept && (LATENCY == 1)) ||
                       ((state_reg == WAIT) && cnt_zero_next);

    mm_delay_counter #(
        .W (CNT_W)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_val  (LOAD_VAL),
        .dec       (state_reg == WAIT),
        .zero_next (cnt_zero_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            op_reg    <= OP_RD;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            ack_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            ack_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg    <= acc_op;
                        addr_reg  <= mm_addr;
                        wdata_reg <= cache_to_mem;
                        busy_reg  <= 1'b1;
                        if (LATENCY == 1) begin
                            state_reg <= ACK;
                            ack_reg   <= 1'b1;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_zero_next) begin
                        state_reg <= ACK;
                        ack_reg   <= 1'b1;
                    end
                end
                ACK: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
            if (enter_ack && (acc_op == OP_RD)) begin
                rdata_reg <= mem_array[acc_addr];
            end
        end
    end

    // Storage is deliberately not reset; commit happens only outside reset.
    always_ff @(posedge clk) begin
        if (rst_n && enter_ack && (acc_op == OP_WR)) begin
            mem_array[acc_addr] <= acc_data;
        end
    end

    assign mem_to_cache = rdata_reg;
    assign mm_ack       = ack_reg;
    assign mm_busy      = busy_reg;

endmodule
